float16_adder: RTL and testbench
================================

Name: float16_adder

Overview:
- Registered IEEE-754 half-precision (binary16) adder: sign[15], exponent[14:10] (bias 15), fraction[9:0].
- Adds two operands; returns the sum plus overflow, zero and NaN flags.
- Used as a single-cycle arithmetic leaf inside datapaths. The companion multiplier uses the same number format.

Parameters:
- None. Widths are fixed by the shared package.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid this cycle.
- num1  in  16  operand A, binary16.
- num2  in  16  operand B, binary16.
- out_valid  out  1  result/flags valid. Equals in_valid delayed 1 cycle.
- result  out  16  sum, binary16.
- overflow  out  1  sum is ±infinity, either because the exponent reached 31 or because an input was infinite.
- zero  out  1  result magnitude is 0.
- nan  out  1  result is NaN.

Behaviour:
- Latency 1 cycle. When in_valid=1, the output registers load the combinational sum at the next rising clk edge. Otherwise they hold their value. No backpressure; a new operation is accepted every cycle.
- Reset (rst_n=0, asynchronous): out_valid=0, result=16'h0000, overflow=0, zero=0, nan=0.
- Input classes:
  - exp=0 is zero. Subnormals are flushed to zero and the sign is kept.
  - exp=31 with frac≠0 is NaN.
  - exp=31 with frac=0 is ±inf.
- Special-case priority, highest first:
  1. Either input is NaN → result=16'h7E00, nan=1.
  2. +inf plus -inf → result=16'h7E00, nan=1.
  3. Either input is inf → result=that infinity, overflow=1.
  4. Otherwise, normal arithmetic.
- Arithmetic:
  - Form 11-bit significands with the hidden 1.
  - Align the smaller-exponent operand by right-shifting it. Keep guard, round and sticky bits.
  - If the exponent difference is ≥13, the smaller operand contributes sticky only.
  - Same signs: add magnitudes. On carry-out, shift right 1 and increment the exponent.
  - Different signs: subtract the smaller magnitude from the larger. The result takes the sign of the larger magnitude. Normalize left with a leading-zero count and decrement the exponent accordingly.
  - Default rounding is truncation (round toward zero).
- Exponent results:
  - Exponent ≥31 after normalize/round → result={sign,5'h1F,10'h0}, overflow=1.
  - Exponent ≤0 after normalize → result=16'h0000, zero=1 (flush to zero, underflow).
  - Exact cancellation → result=16'h0000 (+0), zero=1.
- Flags are mutually exclusive. All three are 0 for a normal finite result.
- Reset mid-operation discards the pending result.

Optional Feature:
- Macro: FLOAT16_ADDER_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even using the guard, round and sticky bits. A rounding carry renormalizes and can trigger overflow.
- Undefined: truncation. The G/R/S logic may be optimized away.

Decomposition:
- Package fp16_pkg holds:
  - constants EXP_W=5, FRAC_W=10, BIAS=15, EXP_MAX=5'h1F, QNAN=16'h7E00;
  - a packed struct typedef fp16_t {sign, exp, frac};
  - class-decode functions is_nan, is_inf, is_zero.
- One sub-module is natural: fp16_normalize. It takes the raw significand and exponent, performs the leading-zero count and shift, and produces the normalized frac/exp plus underflow/overflow indications. It is purely combinational.
- Alignment, add/sub and the output registers stay in float16_adder.

Test Plan:
1. Reset asserted with nonzero outputs pending → all outputs 0 immediately. After release, idle outputs hold.
2. 16'h10A0 + 16'h106C (same exponent) → one cycle later result=16'h1486, all flags 0, out_valid=1.
3. 16'h3C00 + 16'hBE00 (different signs) → result=16'hB800. Then 16'hE49D + 16'h649D → result=16'h0000, zero=1.
4. 16'h7BFF + 16'h7BFF → result=16'h7C00, overflow=1. Also 16'h7C00 + 16'h4B83 → result=16'h7C00, overflow=1.
5. 16'h44FF + 16'h7CFF → result=16'h7E00, nan=1. Also 16'h7C00 + 16'hFC00 → nan=1.
6. Precision loss: 16'h3C00 + 16'h1001 → result=16'h3C00 without the macro, 16'h3C01 with FLOAT16_ADDER_ROUND_NEAREST_EN. Back-to-back valid inputs each produce a result one cycle later.

Source files
------------

// File: rtl/fp16_pkg.sv
// fp16_pkg: binary16 format constants, packed struct and operand class decoders
// shared by the half-precision adder and multiplier.
package fp16_pkg;
    localparam int EXP_W = 5;
    localparam int FRAC_W = 10;
    localparam int BIAS = 15;
    localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;
    localparam logic [15:0] QNAN = 16'h7E00;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    function automatic logic is_nan(input fp16_t x);
        return x.exp == EXP_MAX && x.frac != '0;
    endfunction

    function automatic logic is_inf(input fp16_t x);
        return x.exp == EXP_MAX && x.frac == '0;
    endfunction

    // Subnormals count as zero: they are flushed on entry.
    function automatic logic is_zero(input fp16_t x);
        return x.exp == '0;
    endfunction
endpackage

// File: rtl/fp16_normalize.sv
// fp16_normalize: renormalizes a raw 15-bit sum (carry, hidden, 10 frac, G/R/S)
// against the larger operand's exponent; flags zero, underflow and overflow.
module fp16_normalize (
    input  logic [14:0] sig_i,
    input  logic [4:0]  exp_i,
    output logic [9:0]  frac_o,
    output logic [2:0]  grs_o,
    output logic [4:0]  exp_o,
    output logic        zero_o,
    output logic        ovf_o,
    output logic        unf_o
);
    logic [3:0]  lz;
    logic [13:0] mant;
    logic [6:0]  e;

    always_comb begin
        lz = 4'd14;
        for (int i = 0; i < 14; i++)
            if (sig_i[i]) lz = 4'(13 - i);
        // Carry-out shifts right once, folding the dropped bit into sticky.
        mant = sig_i[14] ? {sig_i[14:2], sig_i[1] | sig_i[0]} : sig_i[13:0] << lz;
        e = sig_i[14] ? {2'b00, exp_i} + 7'd1 : {2'b00, exp_i} - {3'b000, lz};
    end

    assign frac_o = mant[12:3];
    assign grs_o  = mant[2:0];
    assign exp_o  = e[4:0];
    assign zero_o = sig_i == '0;
    assign unf_o  = e[6] || e == '0;
    assign ovf_o  = !e[6] && e >= 7'd31;
endmodule

// File: rtl/float16_adder.sv
// float16_adder: registered binary16 adder with overflow/zero/NaN flags, 1-cycle latency.
// Define FLOAT16_ADDER_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module float16_adder
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] num1,
    input  logic [15:0] num2,
    output logic        out_valid,
    output logic [15:0] result,
    output logic        overflow,
    output logic        zero,
    output logic        nan
);
`ifdef FLOAT16_ADDER_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    fp16_t       a, b, l, s;
    logic        a_big, inc, nan_c, inf_c, ovf_c;
    logic [10:0] sig_l, sig_s;
    logic [4:0]  d;
    logic [3:0]  sh;
    logic [23:0] s_ext;
    logic [13:0] l_al, s_al;
    logic [14:0] raw;
    logic [9:0]  n_frac;
    logic [2:0]  n_grs;
    logic [4:0]  n_exp;
    logic        n_zero, n_ovf, n_unf;
    logic [15:0] rnd;
    logic [15:0] res_d, res_q;
    logic        ovf_d, ovf_q, zero_d, zero_q, nan_d, nan_q, valid_q;

    always_comb begin
        a = num1;
        b = num2;
        a_big = {a.exp, a.frac} >= {b.exp, b.frac};
        l = a_big ? a : b;
        s = a_big ? b : a;
        sig_l = is_zero(l) ? 11'd0 : {1'b1, l.frac};
        sig_s = is_zero(s) ? 11'd0 : {1'b1, s.frac};
        d = l.exp - s.exp;
        // Past 13 places the smaller operand lands entirely in the sticky field.
        sh = d > 5'd13 ? 4'd13 : d[3:0];
        s_ext = {sig_s, 13'd0} >> sh;
        s_al = {s_ext[23:11], |s_ext[10:0]};
        l_al = {sig_l, 3'b000};
        raw = l.sign == s.sign ? {1'b0, l_al} + {1'b0, s_al} : {1'b0, l_al} - {1'b0, s_al};
    end

    fp16_normalize u_norm (
        .sig_i  (raw),
        .exp_i  (l.exp),
        .frac_o (n_frac),
        .grs_o  (n_grs),
        .exp_o  (n_exp),
        .zero_o (n_zero),
        .ovf_o  (n_ovf),
        .unf_o  (n_unf)
    );

    always_comb begin
        nan_c = is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && a.sign != b.sign);
        inf_c = is_inf(a) || is_inf(b);
        inc = RNE && n_grs[2] && (n_grs[1] || n_grs[0] || n_frac[0]);
        // A rounding carry out of the fraction ripples straight into the exponent.
        rnd = {1'b0, n_exp, n_frac} + {15'd0, inc};
        ovf_c = n_ovf || rnd[15:10] >= 6'd31;
        nan_d = nan_c;
        zero_d = !nan_c && !inf_c && (n_zero || n_unf);
        ovf_d = !nan_c && (inf_c || (!n_zero && !n_unf && ovf_c));
        res_d = nan_c  ? QNAN :
                inf_c  ? {is_inf(a) ? a.sign : b.sign, EXP_MAX, 10'd0} :
                zero_d ? 16'h0000 :
                ovf_d  ? {l.sign, EXP_MAX, 10'd0} :
                         {l.sign, rnd[14:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= 16'h0000;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            nan_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                res_q  <= res_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
                nan_q  <= nan_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign result    = res_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign nan       = nan_q;
endmodule

// File: tb/tb_float16_adder.sv
// tb_float16_adder: directed binary16 add vectors with hand-computed results,
// covering reset, specials, cancellation, flush-to-zero and rounding.
module tb_float16_adder;
`ifdef FLOAT16_ADDER_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] num1 = '0, num2 = '0;
    logic        out_valid, overflow, zero, nan;
    logic [15:0] result;
    logic [19:0] obs;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    float16_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .num1      (num1),
        .num2      (num2),
        .out_valid (out_valid),
        .result    (result),
        .overflow  (overflow),
        .zero      (zero),
        .nan       (nan)
    );

    // {out_valid, overflow, zero, nan, result}
    assign obs = {out_valid, overflow, zero, nan, result};

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // f = {overflow, zero, nan}
    task automatic op(input string tag, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] r, input logic [2:0] f);
        @(negedge clk);
        in_valid = 1'b1;
        num1 = x;
        num2 = y;
        @(posedge clk);
        #1;
        check(tag, obs, {1'b1, f, r});
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check("rst_init", obs, 20'h0);
        @(negedge clk);
        rst_n = 1'b1;
        op("two", 16'h3C00, 16'h3C00, 16'h4000, 3'b000);
        @(negedge clk);
        num1 = 16'h7BFF;
        num2 = 16'h7BFF;
        #2 rst_n = 1'b0;
        #1 check("rst_async", obs, 20'h0);
        @(posedge clk);
        #1 check("rst_hold", obs, 20'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("idle_after_rst", obs, 20'h0);

        op("same_exp",      16'h10A0, 16'h106C, 16'h1486, 3'b000);
        op("diff_sign",     16'h3C00, 16'hBE00, 16'hB800, 3'b000);
        op("cancel",        16'hE49D, 16'h649D, 16'h0000, 3'b010);
        op("ovf_exp",       16'h7BFF, 16'h7BFF, 16'h7C00, 3'b100);
        op("inf_in",        16'h7C00, 16'h4B83, 16'h7C00, 3'b100);
        op("neg_inf",       16'hFC00, 16'h3C00, 16'hFC00, 3'b100);
        op("nan_in",        16'h44FF, 16'h7CFF, 16'h7E00, 3'b001);
        op("inf_minus_inf", 16'h7C00, 16'hFC00, 16'h7E00, 3'b001);
        op("nan_over_inf",  16'h7C00, 16'h7D00, 16'h7E00, 3'b001);
        op("sticky",        16'h3C00, 16'h1001, RNE ? 16'h3C01 : 16'h3C00, 3'b000);
        op("tie_even",      16'h3C00, 16'h1000, 16'h3C00, 3'b000);
        op("tie_odd",       16'h3C01, 16'h1000, RNE ? 16'h3C02 : 16'h3C01, 3'b000);
        op("rnd_ovf",       16'h7BFF, 16'h4C00, RNE ? 16'h7C00 : 16'h7BFF, RNE ? 3'b100 : 3'b000);
        op("zero_op",       16'h0000, 16'hC500, 16'hC500, 3'b000);
        op("subnorm",       16'h3C00, 16'h03FF, 16'h3C00, 3'b000);
        op("far",           16'h3C00, 16'h0400, 16'h3C00, 3'b000);
        op("min_norm",      16'h0800, 16'h8400, 16'h0400, 3'b000);
        op("underflow",     16'h0400, 16'h8401, 16'h0000, 3'b010);
        op("carry",         16'h4000, 16'h3C00, 16'h4200, 3'b000);
        op("sub_norm",      16'hC000, 16'h3C00, 16'hBC00, 3'b000);

        @(negedge clk);
        in_valid = 1'b0;
        num1 = 16'h3C00;
        num2 = 16'h3C00;
        @(posedge clk);
        #1 check("idle_hold", obs, {1'b0, 3'b000, 16'hBC00});
        @(posedge clk);
        #1 check("idle_hold2", obs, {1'b0, 3'b000, 16'hBC00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
